dbus_uart_responder: RTL and testbench
======================================

Name: dbus_uart_responder

Overview:
- Responder on the VexRiscv simple data bus (dBus cmd/rsp). It sits beside the RAM in the Arty S7 top level and serves one peripheral address window.
- Exposes a memory-mapped 8N1 UART:
  - TX path: FIFO plus serializer.
  - RX path: synchronizer, deserializer, one-byte holding register.
  - Status register and programmable baud divisor.
- The CPU drives commands; this block accepts them and returns read responses.

Parameters:
- BASE_ADDR, 32'h1000_0000, window base; bits [31:4] are decoded.
- DEFAULT_DIV, 868, reset value of the baud divisor in clocks per bit (100 MHz / 115200).
- TX_DEPTH, 8, TX FIFO depth; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dBus_cmd_valid  in  1  command valid
- dBus_cmd_ready  out  1  command accepted when valid & ready
- dBus_cmd_payload_wr  in  1  1 = write, 0 = read
- dBus_cmd_payload_address  in  32  byte address
- dBus_cmd_payload_data  in  32  write data
- dBus_cmd_payload_size  in  2  access size; ignored, the block always uses full-word semantics
- dBus_rsp_ready  out  1  read response valid, one-cycle pulse
- dBus_rsp_error  out  1  read response error, qualified by dBus_rsp_ready
- dBus_rsp_data  out  32  read response data
- uart_rx  in  1  serial input, asynchronous
- uart_tx  out  1  serial output, idle high

Behaviour:
- Reset (asynchronous, active-high) clears state and sets outputs as follows:
  - Outputs: dBus_cmd_ready=1, dBus_rsp_ready=0, dBus_rsp_error=0, dBus_rsp_data=0, uart_tx=1.
  - Internal: TX FIFO empty, rx_valid=0, all sticky flags 0, baud_div=DEFAULT_DIV, both FSMs in IDLE.
  - Reset mid-frame aborts it; uart_tx returns high immediately.
- Handshake:
  - Accept occurs on valid & ready.
  - A read accepted in cycle N produces dBus_rsp_ready=1 in cycle N+1 for exactly one cycle, with data and error.
  - dBus_cmd_ready is low only during that response cycle, so at most one read is outstanding. Back-to-back reads therefore complete every 2 cycles.
  - Writes produce no response.
  - dBus_rsp_data=0 whenever dBus_rsp_ready=0.
- Decode:
  - In window iff address[31:4]==BASE_ADDR[31:4].
  - Register select is address[3:2]; address[1:0] is ignored.
  - Out-of-window or reserved read: rsp_error=1, data=0.
  - Out-of-window or reserved write: silently dropped, no state change.
- Register map:
  - 0x0 DATA
    - Write pushes data[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_ovf is set.
    - Read returns {23'b0, rx_valid, rx_byte} and clears rx_valid; rx_byte is retained.
  - 0x4 STATUS
    - Read returns {26'b0, frame_err, tx_ovf, rx_ovr, rx_valid, tx_full, tx_empty}.
    - tx_empty means the FIFO is empty and the serializer is idle.
    - Write-1-to-clear on bits [5:3].
  - 0x8 BAUD
    - Read returns {16'b0, baud_div}.
    - Write stores data[15:0]; values below 8 are stored as 8.
    - A change takes effect at the next frame start; a frame in flight keeps its divisor.
  - 0xC reserved.
- TX FSM:
  - States: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each bit lasts baud_div clocks.
  - The FIFO pops on IDLE->START.
  - uart_tx is registered, so the start bit appears 1 cycle after the pop.
  - Back-to-back bytes have no idle gap.
- RX path:
  - uart_rx passes through a 2-FF synchronizer.
  - FSM: IDLE -> START -> DATA -> STOP.
  - IDLE -> START on a synchronized falling edge.
  - START samples at baud_div/2 (floor); a high sample is treated as a glitch and returns to IDLE.
  - Data and stop bits are sampled every baud_div thereafter.
  - Stop bit = 0: byte discarded, frame_err set, return to IDLE.
  - Stop bit = 1, rx_valid=0: rx_byte loaded, rx_valid=1.
  - Stop bit = 1, rx_valid=1: new byte discarded, rx_ovr set.
  - Simultaneous DATA read and byte completion in the same cycle:
    - The response returns the old byte.
    - The new byte loads and rx_valid ends at 1.
    - No overrun is flagged.
- Simultaneous events:
  - A DATA write on the same cycle as a TX pop from a full FIFO is accepted; occupancy is unchanged.
  - A STATUS W1C clear and a set event in the same cycle: set wins.

Test Plan:
- Reset: assert reset mid-TX-frame -> uart_tx=1 within 0 cycles; STATUS read = 0x1; BAUD read = 868.
- TX byte: baud_div=16; write 0x55 to DATA. Required response:
  - uart_tx low for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high.
  - tx_empty returns to 1 after the stop bit.
- TX overflow: with baud_div=16, write 10 bytes back-to-back -> 9 bytes transmitted (8 in FIFO + 1 in flight); STATUS bit4=1; writing 0x10 to STATUS clears it.
- RX byte: baud_div=16; drive 0xA3 as 8N1 -> STATUS bit2=1; DATA read returns 0x1A3 with rsp_ready exactly 1 cycle after accept; a second read returns 0x0A3.
- RX errors:
  - A second frame received before DATA is read -> rx_ovr=1, and rx_byte keeps the first value.
  - A frame with stop bit 0 -> frame_err=1 and rx_valid unchanged.
  - A 4-cycle low glitch -> no state change.
- Decode: read 0x1000_000C and 0x2000_0000 -> rsp_error=1, data=0; write to 0x1000_000C -> no state change; BAUD write of 3 -> reads back 8.

Source files
------------

// File: rtl/dbus_uart_responder.sv
// dbus_uart_responder: VexRiscv simple-dBus responder exposing an 8N1 UART.
//   Register window (word-decoded, address[1:0] ignored):
//     0x0 DATA   W: push byte to TX FIFO   R: {rx_valid, rx_byte}, clears rx_valid
//     0x4 STATUS R: {frame_err, tx_ovf, rx_ovr, rx_valid, tx_full, tx_empty}, W1C [5:3]
//     0x8 BAUD   R/W: clocks per bit (min 8)
//     0xC reserved (read error, write dropped)
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   dBus_cmd_*                  command channel (valid/ready, wr, address, data, size)
//   dBus_rsp_*                  read response (one-cycle ready pulse, error, data)
//   uart_rx / uart_tx           serial lines, idle high
module dbus_uart_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned DEFAULT_DIV = 868,
  parameter int unsigned TX_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic        dBus_cmd_payload_wr,
  input  logic [31:0] dBus_cmd_payload_address,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [1:0]  dBus_cmd_payload_size,
  output logic        dBus_rsp_ready,
  output logic        dBus_rsp_error,
  output logic [31:0] dBus_rsp_data,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int unsigned AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Bus side
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        accept, rd_acc, wr_acc, in_win;
  logic [1:0]  sel;
  logic        wr_data, wr_status, wr_baud, rd_data;

  // Config and flags
  logic [15:0] baud_div_q, baud_div_d;
  logic        tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d;
  logic [2:0]  w1c;

  // TX FIFO
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        fifo_empty, fifo_full, push, tx_pop, tx_ovf_set;

  // TX serializer
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_q, tx_d, tx_launch, tx_bit_end, tx_empty;

  // RX deserializer
  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_valid_q, rx_valid_d, rx_done, rx_ferr, rx_ovr_set;

  logic        unused_sigs;
  assign unused_sigs = ^{dBus_cmd_payload_size, dBus_cmd_payload_address[1:0],
                         dBus_cmd_payload_data[31:16]};

  // ---------------------------------------------------------------- decode
  assign dBus_cmd_ready = ~rsp_valid_q;
  assign accept    = dBus_cmd_valid & dBus_cmd_ready;
  assign rd_acc    = accept & ~dBus_cmd_payload_wr;
  assign wr_acc    = accept & dBus_cmd_payload_wr;
  assign in_win    = dBus_cmd_payload_address[31:4] == BASE_ADDR[31:4];
  assign sel       = dBus_cmd_payload_address[3:2];
  assign wr_data   = wr_acc & in_win & (sel == 2'd0);
  assign wr_status = wr_acc & in_win & (sel == 2'd1);
  assign wr_baud   = wr_acc & in_win & (sel == 2'd2);
  assign rd_data   = rd_acc & in_win & (sel == 2'd0);

  assign tx_empty  = fifo_empty & (tx_state_q == TxIdle);

  always_comb begin
    rsp_valid_d = rd_acc;
    rsp_err_d   = rd_acc & (~in_win | (sel == 2'd3));
    rsp_data_d  = '0;
    if (rd_acc && in_win) begin
      unique case (sel)
        2'd0:    rsp_data_d = {23'b0, rx_valid_q, rx_byte_q};
        2'd1:    rsp_data_d = {26'b0, frame_err_q, tx_ovf_q, rx_ovr_q, rx_valid_q,
                               fifo_full, tx_empty};
        2'd2:    rsp_data_d = {16'b0, baud_div_q};
        default: rsp_data_d = '0;
      endcase
    end
  end

  assign dBus_rsp_ready = rsp_valid_q;
  assign dBus_rsp_error = rsp_err_q;
  assign dBus_rsp_data  = rsp_data_q;

  // ---------------------------------------------------------------- config / flags
  always_comb begin
    baud_div_d = baud_div_q;
    if (wr_baud) begin
      baud_div_d = (dBus_cmd_payload_data[15:0] < 16'd8) ? 16'd8
                                                          : dBus_cmd_payload_data[15:0];
    end
    w1c         = wr_status ? dBus_cmd_payload_data[5:3] : 3'b000;
    // Set events override a simultaneous clear.
    rx_ovr_d    = (rx_ovr_q & ~w1c[0]) | rx_ovr_set;
    tx_ovf_d    = (tx_ovf_q & ~w1c[1]) | tx_ovf_set;
    frame_err_d = (frame_err_q & ~w1c[2]) | rx_ferr;
  end

  // ---------------------------------------------------------------- TX FIFO
  assign fifo_empty = wr_ptr_q == rd_ptr_q;
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign push       = wr_data & (~fifo_full | tx_pop);
  assign tx_ovf_set = wr_data & fifo_full & ~tx_pop;

  always_comb begin
    wr_ptr_d = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = tx_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= dBus_cmd_payload_data[7:0];
  end

  // ---------------------------------------------------------------- TX FSM
  assign tx_bit_end = tx_cnt_q == (tx_div_q - 16'd1);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    tx_launch  = 1'b0;
    unique case (tx_state_q)
      TxIdle: tx_launch = ~fifo_empty;
      TxStart: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TxData;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TxStop;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TxIdle;
          // Chain straight into the next start bit so there is no idle gap.
          tx_launch  = ~fifo_empty;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    if (tx_launch) begin
      tx_state_d = TxStart;
      tx_cnt_d   = '0;
      tx_div_d   = baud_div_q;
      tx_shift_d = fifo_mem[rd_ptr_q[AW-1:0]];
      tx_d       = 1'b0;
    end
  end

  assign tx_pop  = tx_launch;
  assign uart_tx = tx_q;

  // ---------------------------------------------------------------- RX FSM
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
          rx_div_d   = baud_div_q;
        end
      end
      RxStart: begin
        if (rx_cnt_q == ((rx_div_q >> 1) - 16'd1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // High at mid start bit: a glitch, not a frame.
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxData: begin
        if (rx_cnt_q == (rx_div_q - 16'd1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == (rx_div_q - 16'd1)) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          rx_done    = rx_sync_q;
          rx_ferr    = ~rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // A DATA read in the completion cycle frees the holding register, so no overrun.
  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q & ~rd_data;
    rx_ovr_set = 1'b0;
    if (rx_done) begin
      if (!rx_valid_q || rd_data) begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_set = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      baud_div_q  <= 16'(DEFAULT_DIV);
      tx_ovf_q    <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_div_q    <= 16'(DEFAULT_DIV);
      tx_shift_q  <= '0;
      tx_bit_q    <= '0;
      tx_q        <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_div_q    <= 16'(DEFAULT_DIV);
      rx_shift_q  <= '0;
      rx_bit_q    <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      baud_div_q  <= baud_div_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovr_q    <= rx_ovr_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_q        <= tx_d;
      rx_meta_q   <= uart_rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_dbus_uart_responder.sv
module tb_dbus_uart_responder;

  localparam logic [31:0] A_DATA   = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h1000_0004;
  localparam logic [31:0] A_BAUD   = 32'h1000_0008;
  localparam logic [31:0] A_RSVD   = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dBus_cmd_valid = 1'b0;
  logic        dBus_cmd_ready;
  logic        dBus_cmd_payload_wr = 1'b0;
  logic [31:0] dBus_cmd_payload_address = '0;
  logic [31:0] dBus_cmd_payload_data = '0;
  logic [1:0]  dBus_cmd_payload_size = 2'd2;
  logic        dBus_rsp_ready;
  logic        dBus_rsp_error;
  logic [31:0] dBus_rsp_data;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbus_uart_responder dut (
    .clk                      (clk),
    .reset                    (reset),
    .dBus_cmd_valid           (dBus_cmd_valid),
    .dBus_cmd_ready           (dBus_cmd_ready),
    .dBus_cmd_payload_wr      (dBus_cmd_payload_wr),
    .dBus_cmd_payload_address (dBus_cmd_payload_address),
    .dBus_cmd_payload_data    (dBus_cmd_payload_data),
    .dBus_cmd_payload_size    (dBus_cmd_payload_size),
    .dBus_rsp_ready           (dBus_rsp_ready),
    .dBus_rsp_error           (dBus_rsp_error),
    .dBus_rsp_data            (dBus_rsp_data),
    .uart_rx                  (uart_rx),
    .uart_tx                  (uart_tx)
  );

  // Bus tasks: called at a negedge, return at a negedge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
    dBus_cmd_valid           = 1'b1;
    dBus_cmd_payload_wr      = 1'b1;
    dBus_cmd_payload_address = addr;
    dBus_cmd_payload_data    = wdata;
    @(negedge clk);
    dBus_cmd_valid      = 1'b0;
    dBus_cmd_payload_wr = 1'b0;
  endtask

  // lat_ok: response present exactly one cycle after accept and gone the cycle after.
  task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata,
                          output logic err, output logic lat_ok);
    dBus_cmd_valid           = 1'b1;
    dBus_cmd_payload_wr      = 1'b0;
    dBus_cmd_payload_address = addr;
    @(negedge clk);
    rdata          = dBus_rsp_data;
    err            = dBus_rsp_error;
    lat_ok         = dBus_rsp_ready & ~dBus_cmd_ready;
    dBus_cmd_valid = 1'b0;
    @(negedge clk);
    lat_ok = lat_ok & ~dBus_rsp_ready & (dBus_rsp_data == 32'd0);
  endtask

  // Drive one 8N1 frame at 16 clocks per bit.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Capture one TX frame at 16 clocks per bit by mid-bit sampling; returns mid stop bit.
  task automatic tx_capture(output logic [7:0] b, output logic ok);
    int n = 0;
    ok = 1'b1;
    b  = '0;
    while (uart_tx === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      ok = 1'b0;
    end else begin
      repeat (8) @(negedge clk);
      if (uart_tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (16) @(negedge clk);
      if (uart_tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e, l;
    int n;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, uart_tx} !== 4'b1001 ||
        dBus_rsp_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b rsp=%b err=%b tx=%b data=%h expected 1 0 0 1 0",
               dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, uart_tx, dBus_rsp_data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_read(A_STATUS, d, e, l);
    checks++;
    if (d !== 32'h1 || e !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: got %h err=%b expected 00000001 err=0", d, e);
    end
    bus_read(A_BAUD, d, e, l);
    checks++;
    if (d !== 32'd868) begin
      failures++;
      $display("FAIL reset_baud: got %0d expected 868", d);
    end
    // Reset in the middle of a start bit.
    bus_write(A_DATA, 32'hFF);
    n = 0;
    while (uart_tx === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uart_tx !== 1'b0) begin
      failures++;
      $display("FAIL reset_frame_start: got tx=%b expected 0", uart_tx);
    end
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin
      failures++;
      $display("FAIL reset_midframe_tx: got %b expected 1", uart_tx);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_read(A_STATUS, d, e, l);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL reset_midframe_status: got %h expected 00000001", d);
    end
    bus_read(A_BAUD, d, e, l);
    checks++;
    if (d !== 32'd868) begin
      failures++;
      $display("FAIL reset_midframe_baud: got %0d expected 868", d);
    end
  endtask

  task automatic test_tx();
    logic [31:0] d;
    logic e, l, exp_bit;
    logic [7:0] pat;
    int n, bad;
    pat = 8'h55;
    bus_write(A_BAUD, 32'd16);
    bus_write(A_DATA, 32'h55);
    n = 0;
    while (uart_tx === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL tx_start_latency: got %0d cycles expected 1", n);
    end
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      if (i < 16)       exp_bit = 1'b0;
      else if (i < 144) exp_bit = pat[(i - 16) / 16];
      else              exp_bit = 1'b1;
      if (uart_tx !== exp_bit) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL tx_waveform_55: got %0d wrong samples expected 0", bad);
    end
    bus_read(A_STATUS, d, e, l);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL tx_empty_after_stop: got %h expected 00000001", d);
    end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] got [9];
    logic ok [9];
    logic [31:0] d;
    logic e, l;
    int bad;
    fork
      begin
        for (int i = 0; i < 10; i++) bus_write(A_DATA, 32'h10 + 32'(i));
      end
      begin
        for (int k = 0; k < 9; k++) tx_capture(got[k], ok[k]);
      end
    join
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (ok[k] !== 1'b1 || got[k] !== 8'(8'h10 + k)) begin
        failures++;
        $display("FAIL tx_ovf_frame%0d: got %h ok=%b expected %h ok=1",
                 k, got[k], ok[k], 8'(8'h10 + k));
      end
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (uart_tx !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL tx_ovf_no_tenth: got %0d low samples expected 0", bad);
    end
    bus_read(A_STATUS, d, e, l);
    checks++;
    if (d !== 32'h11) begin
      failures++;
      $display("FAIL tx_ovf_flag: got %h expected 00000011", d);
    end
    bus_write(A_STATUS, 32'h10);
    bus_read(A_STATUS, d, e, l);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL tx_ovf_clear: got %h expected 00000001", d);
    end
  endtask

  task automatic test_rx();
    logic [31:0] d;
    logic e, l;
    send_rx(8'hA3, 1'b1);
    bus_read(A_STATUS, d, e, l);
    checks++;
    if (d !== 32'h5) begin
      failures++;
      $display("FAIL rx_status_valid: got %h expected 00000005", d);
    end
    bus_read(A_DATA, d, e, l);
    checks++;
    if (d !== 32'h1A3 || e !== 1'b0 || l !== 1'b1) begin
      failures++;
      $display("FAIL rx_data_first: got %h err=%b lat=%b expected 000001a3 err=0 lat=1",
               d, e, l);
    end
    bus_read(A_DATA, d, e, l);
    checks++;
    if (d !== 32'h0A3) begin
      failures++;
      $display("FAIL rx_data_second: got %h expected 000000a3", d);
    end
  endtask

  task automatic test_rx_errors();
    logic [31:0] d;
    logic e, l;
    send_rx(8'h3C, 1'b1);
    send_rx(8'h77, 1'b1);
    bus_read(A_STATUS, d, e, l);
    checks++;
    if (d !== 32'hD) begin
      failures++;
      $display("FAIL rx_ovr_status: got %h expected 0000000d", d);
    end
    bus_read(A_DATA, d, e, l);
    checks++;
    if (d !== 32'h13C) begin
      failures++;
      $display("FAIL rx_ovr_keeps_first: got %h expected 0000013c", d);
    end
    bus_write(A_STATUS, 32'h08);
    bus_read(A_STATUS, d, e, l);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL rx_ovr_clear: got %h expected 00000001", d);
    end
    send_rx(8'h5A, 1'b1);
    send_rx(8'h55, 1'b0);
    bus_read(A_STATUS, d, e, l);
    checks++;
    if (d !== 32'h25) begin
      failures++;
      $display("FAIL rx_frame_err_status: got %h expected 00000025", d);
    end
    bus_read(A_DATA, d, e, l);
    checks++;
    if (d !== 32'h15A) begin
      failures++;
      $display("FAIL rx_frame_err_byte: got %h expected 0000015a", d);
    end
    bus_write(A_STATUS, 32'h20);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(A_STATUS, d, e, l);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL rx_glitch_status: got %h expected 00000001", d);
    end
    bus_read(A_DATA, d, e, l);
    checks++;
    if (d !== 32'h05A) begin
      failures++;
      $display("FAIL rx_glitch_data: got %h expected 0000005a", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] seen;
    int bad;
    bad = 0;
    dBus_cmd_valid           = 1'b1;
    dBus_cmd_payload_wr      = 1'b0;
    dBus_cmd_payload_address = A_BAUD;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen[i] = dBus_rsp_ready;
      if (dBus_rsp_ready === 1'b1 && dBus_rsp_data !== 32'd16) bad++;
    end
    dBus_cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (seen !== 6'b010101 || bad != 0) begin
      failures++;
      $display("FAIL b2b_reads: got pattern %b bad_data=%0d expected 010101 0", seen, bad);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic e, l;
    bus_read(A_RSVD, d, e, l);
    checks++;
    if (d !== 32'd0 || e !== 1'b1 || l !== 1'b1) begin
      failures++;
      $display("FAIL dec_reserved_read: got %h err=%b lat=%b expected 0 err=1 lat=1", d, e, l);
    end
    bus_read(32'h2000_0000, d, e, l);
    checks++;
    if (d !== 32'd0 || e !== 1'b1) begin
      failures++;
      $display("FAIL dec_outside_read: got %h err=%b expected 0 err=1", d, e);
    end
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    bus_write(32'h2000_0008, 32'd100);
    bus_write(32'h2000_0000, 32'h41);
    bus_read(A_STATUS, d, e, l);
    checks++;
    if (d !== 32'h1 || e !== 1'b0) begin
      failures++;
      $display("FAIL dec_dropped_status: got %h err=%b expected 00000001 err=0", d, e);
    end
    bus_read(32'h1000_000B, d, e, l);
    checks++;
    if (d !== 32'd16) begin
      failures++;
      $display("FAIL dec_dropped_baud: got %0d expected 16", d);
    end
    bus_write(A_BAUD, 32'd3);
    bus_read(A_BAUD, d, e, l);
    checks++;
    if (d !== 32'd8) begin
      failures++;
      $display("FAIL baud_min_clamp: got %0d expected 8", d);
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_tx_overflow();
    test_rx();
    test_rx_errors();
    test_back_to_back();
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
